// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch types and constants
package core_pkg;

  // Fetch FSM. HALT can only be entered on an error and is left only by reset.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Sticky error code, mapped directly onto the 2-bit err output.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10
  } fetch_err_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC and error select for the fetch front end
//
// Ports:
//   pc              current PC register value
//   redirect        branch/jump taken this cycle
//   redirect_target new PC requested by the redirect
//   advance         fetch buffer can take a new word (!if_valid || if_ready)
//   state           current fetch FSM state
//   pc_nxt          value to load into the PC register
//   capture         load Instr/pc into the fetch buffer
//   flush           invalidate the fetch buffer (redirect)
//   halt_req        move to HALT and record err_code
//   err_code        error to record when halt_req is set
module pc_next
  import core_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 20
) (
  input  logic [31:0]  pc,
  input  logic         redirect,
  input  logic [31:0]  redirect_target,
  input  logic         advance,
  input  fetch_state_t state,
  output logic [31:0]  pc_nxt,
  output logic         capture,
  output logic         flush,
  output logic         halt_req,
  output fetch_err_t   err_code
);

  // Compare the word index against 2**ADDRESS_WIDTH in 64 bits so the limit
  // itself never overflows, whatever ADDRESS_WIDTH is.
  localparam logic [63:0] WORD_LIMIT = 64'd1 << ADDRESS_WIDTH;

  logic pc_in_range;
  assign pc_in_range = ({34'd0, pc[31:2]} < WORD_LIMIT);

  always_comb begin
    pc_nxt   = pc;
    capture  = 1'b0;
    flush    = 1'b0;
    halt_req = 1'b0;
    err_code = ERR_NONE;

    if (state == RUN) begin
      // Redirect wins over advance; a misaligned target halts without
      // touching the PC.
      if (redirect) begin
        if (redirect_target[1:0] != 2'b00) begin
          halt_req = 1'b1;
          err_code = ERR_MISALIGN;
        end else begin
          pc_nxt = redirect_target;
          flush  = 1'b1;
        end
      end else if (advance) begin
        if (!pc_in_range) begin
          halt_req = 1'b1;
          err_code = ERR_RANGE;
        end else begin
          capture = 1'b1;
          pc_nxt  = pc + 32'(INSTR_BYTES);
        end
      end
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch front end with one-entry fetch buffer
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   PC               byte address to instruction memory (PC register)
//   Instr            word returned combinationally by instruction memory
//   redirect         branch/jump taken, load redirect_target
//   redirect_target  new PC
//   if_valid         fetch buffer holds an instruction
//   if_ready         decode accepts the buffer this cycle
//   if_instr, if_pc  buffered instruction and its PC
//   err              sticky error: 00 none, 01 misaligned, 10 out of range
//   instr_count      number of accepted instructions
module pc_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [31:0]           PC,
  input  logic [DATA_WIDTH-1:0] Instr,
  input  logic                  redirect,
  input  logic [31:0]           redirect_target,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [31:0]           if_pc,
  output logic [1:0]            err,
  output logic [31:0]           instr_count
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  fetch_err_t   err_q;

  logic         advance;
  logic [31:0]  pc_nxt;
  logic         capture;
  logic         flush;
  logic         halt_req;
  fetch_err_t   err_code;

  assign advance = !if_valid || if_ready;
  assign err     = err_q;

  pc_next #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_pc_next (
    .pc              (PC),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .advance         (advance),
    .state           (state),
    .pc_nxt          (pc_nxt),
    .capture         (capture),
    .flush           (flush),
    .halt_req        (halt_req),
    .err_code        (err_code)
  );

  always_comb begin
    state_nxt = state;
    if (halt_req) begin
      state_nxt = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      err_q       <= ERR_NONE;
      instr_count <= '0;
    end else begin
      PC <= pc_nxt;

      // A handshake in the same cycle as a redirect or error still counts;
      // in HALT if_valid is already low, so the count holds there.
      if (if_valid && if_ready) begin
        instr_count <= instr_count + 32'd1;
      end

      if (capture) begin
        if_valid <= 1'b1;
        if_instr <= Instr;
        if_pc    <= PC;
      end else if (flush || halt_req) begin
        if_valid <= 1'b0;
      end

      if (halt_req) begin
        err_q <= err_code;
      end
    end
  end

endmodule
